nexus_hier_bitset: RTL and testbench
====================================

NEXUS_HIER_BITSET -- requirements
Module: nexus_hier_bitset

Interface
REQ-001 SHALL have parameter L1_SIZE, default 16: summary-level width; power of two, 2..64.
REQ-002 SHALL have parameter L2_SIZE, default 16: leaf-row width; power of two, 2..64.
REQ-003 SHALL have parameter LOW_FIRST, default 1: 1 = lowest index wins search, 0 = highest index wins.
REQ-004 SHALL derive BUCKETS = L1_SIZE*L2_SIZE, IDX_W = $clog2(BUCKETS); bucket idx = {row, col}, row in the upper $clog2(L1_SIZE) bits.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_arst  input  1  asynchronous, active-high reset.
REQ-007 i_set_valid  input  1  mark bucket i_set_idx non-empty.
REQ-008 i_set_idx  input  IDX_W  bucket to set.
REQ-009 i_clr_valid  input  1  mark bucket i_clr_idx empty.
REQ-010 i_clr_idx  input  IDX_W  bucket to clear.
REQ-011 i_query_valid  input  1  start a best-bucket search this cycle.
REQ-012 o_res_valid  output  1  search result present, one-cycle pulse per query.
REQ-013 o_res_found  output  1  at least one bucket was set in the searched snapshot.
REQ-014 o_res_idx  output  IDX_W  winning bucket; 0 when o_res_found = 0.
REQ-015 o_empty  output  1  registered; 1 when no bucket set.
REQ-016 o_occupancy  output  IDX_W+1  number of set buckets (see Configuration).

Function
REQ-017 SHALL hold L1_SIZE leaf rows of L2_SIZE bits plus an L1 summary register where summary[r] = OR(row r) after every update.
REQ-018 Set and clear SHALL take effect on the rising edge ending the cycle they are asserted; visible to queries from the next cycle.
REQ-019 Set and clear on different buckets same cycle SHALL both apply, including within one row.
REQ-020 Set and clear on the same bucket same cycle: set SHALL win; bit ends 1.
REQ-021 Set of an already-set bucket and clear of an already-clear bucket SHALL be no-ops.
REQ-022 Search SHALL be a 2-stage pipeline: query in cycle N sees bitmap state at start of cycle N; o_res_valid/found/idx asserted in cycle N+2.
REQ-023 Stage 1 SHALL register the priority-encoded L1 winner, any-valid flag, and a copy of the winning leaf row; stage 2 SHALL priority-encode the captured row and register the result.
REQ-024 Pipeline SHALL accept one query per cycle, back-to-back, no stall; results in query order.
REQ-025 Updates in cycles N, N+1 SHALL NOT alter the result of a query issued in cycle N.
REQ-026 Priority direction per LOW_FIRST SHALL apply identically at both levels.
REQ-027 o_res_found = 0 SHALL force o_res_idx = 0.
REQ-028 o_empty SHALL equal NOR of the next-state summary, registered (updates in cycle N reflected in cycle N+1).

Reset
REQ-029 i_arst SHALL asynchronously clear all rows, summary, pipeline valids and result registers; o_res_valid = 0, o_res_found = 0, o_res_idx = 0, o_empty = 1, o_occupancy = 0.
REQ-030 Queries in flight at reset SHALL be discarded; no o_res_valid pulse after release for them.
REQ-031 First set/clear/query SHALL be honoured in the first cycle after i_arst deasserts.

Configuration
REQ-032 Macro NEXUS_BITSET_OCC_COUNT_EN defined: o_occupancy SHALL be a registered counter, +1 per effective set (bit 0->1), -1 per effective clear (bit 1->0, not overridden by REQ-020), net change applied same edge; range 0..BUCKETS, never wraps.
REQ-033 Macro undefined: o_occupancy SHALL be tied to 0 and no counter logic instantiated; all other behaviour identical.

Verification
REQ-034 Defaults, LOW_FIRST=1: set 0x37, 0xA2, 0x35; query -> 2 cycles later found=1, idx=0x35; occupancy=3 (macro on).
REQ-035 Defaults, LOW_FIRST=0: set 0x05, 0xF1; query -> idx=0xF1; clear 0xF1, query next cycle -> idx=0x05.
REQ-036 Same cycle set 0x40 and clear 0x40 on empty set -> bit set, occupancy=1, o_empty=0 next cycle; clear 0x40 alone -> o_empty=1, query -> found=0, idx=0.
REQ-037 Set 0x10; query cycle N and clear 0x10 cycle N -> result N+2 found=1 idx=0x10; query N+1 -> found=0.
REQ-038 Back-to-back queries 4 cycles while setting 0x80,0x70,0x60,0x50 one per cycle -> four consecutive results found=0, 0x80, 0x70, 0x60.
REQ-039 L1_SIZE=4, L2_SIZE=8: set 31 and 0, reset mid-query -> no result pulse, o_empty=1, occupancy=0; post-reset query -> found=0.

Source files
------------

// File: rtl/nexus_hier_bitset.sv
// Two-level hierarchical bitset with a pipelined best-bucket search.
// Optional occupancy counter: define NEXUS_BITSET_OCC_COUNT_EN.
module nexus_hier_bitset #(
    parameter int L1_SIZE   = 16,
    parameter int L2_SIZE   = 16,
    parameter int LOW_FIRST = 1,
    localparam int BUCKETS  = L1_SIZE * L2_SIZE,
    localparam int IDX_W    = $clog2(BUCKETS)
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_set_valid,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic             i_clr_valid,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic             i_query_valid,
    output logic             o_res_valid,
    output logic             o_res_found,
    output logic [IDX_W-1:0] o_res_idx,
    output logic             o_empty,
    output logic [IDX_W:0]   o_occupancy
);

    localparam int L1_W  = $clog2(L1_SIZE);
    localparam int L2_W  = $clog2(L2_SIZE);
    localparam int OCC_W = IDX_W + 1;

    function automatic logic [L1_W-1:0] enc_l1(input logic [L1_SIZE-1:0] v);
        logic [L1_W-1:0] r;
        r = '0;
        if (LOW_FIRST != 0) begin
            for (int i = L1_SIZE - 1; i >= 0; i--)
                if (v[i]) r = L1_W'(i);
        end else begin
            for (int i = 0; i < L1_SIZE; i++)
                if (v[i]) r = L1_W'(i);
        end
        return r;
    endfunction

    function automatic logic [L2_W-1:0] enc_l2(input logic [L2_SIZE-1:0] v);
        logic [L2_W-1:0] r;
        r = '0;
        if (LOW_FIRST != 0) begin
            for (int i = L2_SIZE - 1; i >= 0; i--)
                if (v[i]) r = L2_W'(i);
        end else begin
            for (int i = 0; i < L2_SIZE; i++)
                if (v[i]) r = L2_W'(i);
        end
        return r;
    endfunction

    logic [L1_SIZE-1:0][L2_SIZE-1:0] rows_q;
    logic [L1_SIZE-1:0][L2_SIZE-1:0] rows_d;
    logic [L1_SIZE-1:0]              summary_q;
    logic [L1_SIZE-1:0]              summary_d;
    logic                            empty_q;

    logic [L1_W-1:0] set_row;
    logic [L2_W-1:0] set_col;
    logic [L1_W-1:0] clr_row;
    logic [L2_W-1:0] clr_col;

    assign set_row = i_set_idx[IDX_W-1:L2_W];
    assign set_col = i_set_idx[L2_W-1:0];
    assign clr_row = i_clr_idx[IDX_W-1:L2_W];
    assign clr_col = i_clr_idx[L2_W-1:0];

    // Clear is applied before set so a same-bucket collision leaves the bit set.
    always_comb begin
        rows_d = rows_q;
        if (i_clr_valid) rows_d[clr_row][clr_col] = 1'b0;
        if (i_set_valid) rows_d[set_row][set_col] = 1'b1;
        for (int r = 0; r < L1_SIZE; r++)
            summary_d[r] = |rows_d[r];
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rows_q    <= '0;
            summary_q <= '0;
            empty_q   <= 1'b1;
        end else begin
            rows_q    <= rows_d;
            summary_q <= summary_d;
            empty_q   <= ~|summary_d;
        end
    end

    assign o_empty = empty_q;

    logic [L1_W-1:0]    l1_win;
    logic               s1_valid;
    logic               s1_any;
    logic [L1_W-1:0]    s1_row_idx;
    logic [L2_SIZE-1:0] s1_row;

    assign l1_win = enc_l1(summary_q);

    // Stage 1 snapshots the winning row so later updates cannot disturb it.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            s1_valid   <= 1'b0;
            s1_any     <= 1'b0;
            s1_row_idx <= '0;
            s1_row     <= '0;
        end else begin
            s1_valid   <= i_query_valid;
            s1_any     <= |summary_q;
            s1_row_idx <= l1_win;
            s1_row     <= rows_q[l1_win];
        end
    end

    logic [L2_W-1:0] l2_win;
    logic            s1_hit;

    assign l2_win = enc_l2(s1_row);
    assign s1_hit = s1_valid & s1_any;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_res_valid <= 1'b0;
            o_res_found <= 1'b0;
            o_res_idx   <= '0;
        end else begin
            o_res_valid <= s1_valid;
            o_res_found <= s1_hit;
            o_res_idx   <= s1_hit ? {s1_row_idx, l2_win} : '0;
        end
    end

`ifdef NEXUS_BITSET_OCC_COUNT_EN
    logic [OCC_W-1:0] occ_q;
    logic             set_eff;
    logic             clr_eff;

    // A clear only counts when the bit was set and no same-bucket set overrides it.
    assign set_eff = i_set_valid && !rows_q[set_row][set_col];
    assign clr_eff = i_clr_valid && rows_q[clr_row][clr_col] &&
                     !(i_set_valid && (i_set_idx == i_clr_idx));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) occ_q <= '0;
        else        occ_q <= occ_q + OCC_W'(set_eff) - OCC_W'(clr_eff);
    end

    assign o_occupancy = occ_q;
`else
    assign o_occupancy = '0;
`endif

endmodule

// File: tb/tb_nexus_hier_bitset.sv
// Scoreboard bench for nexus_hier_bitset: three instances cover
// low-first defaults, high-first priority and a small 4x8 geometry.
module tb_nexus_hier_bitset;

`ifdef NEXUS_BITSET_OCC_COUNT_EN
    localparam bit OCC_ON = 1'b1;
`else
    localparam bit OCC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] occ(input int n);
        return OCC_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance 0: defaults, lowest index wins
    logic       arst0, sv0, cv0, qv0;
    logic [7:0] si0, ci0;
    logic       rv0, rf0, em0;
    logic [7:0] ri0;
    logic [8:0] oc0;
    logic [8:0] q0[$];

    nexus_hier_bitset #(.L1_SIZE(16), .L2_SIZE(16), .LOW_FIRST(1)) u0 (
        .i_clk(clk), .i_arst(arst0),
        .i_set_valid(sv0), .i_set_idx(si0),
        .i_clr_valid(cv0), .i_clr_idx(ci0),
        .i_query_valid(qv0),
        .o_res_valid(rv0), .o_res_found(rf0), .o_res_idx(ri0),
        .o_empty(em0), .o_occupancy(oc0)
    );

    // Instance 1: highest index wins
    logic       sv1, cv1, qv1;
    logic [7:0] si1, ci1;
    logic       rv1, rf1, em1;
    logic [7:0] ri1;
    logic [8:0] oc1;
    logic [8:0] q1[$];

    nexus_hier_bitset #(.L1_SIZE(16), .L2_SIZE(16), .LOW_FIRST(0)) u1 (
        .i_clk(clk), .i_arst(arst0),
        .i_set_valid(sv1), .i_set_idx(si1),
        .i_clr_valid(cv1), .i_clr_idx(ci1),
        .i_query_valid(qv1),
        .o_res_valid(rv1), .o_res_found(rf1), .o_res_idx(ri1),
        .o_empty(em1), .o_occupancy(oc1)
    );

    // Instance 2: 4 x 8 geometry with its own reset
    logic       arst2, sv2, cv2, qv2;
    logic [4:0] si2, ci2;
    logic       rv2, rf2, em2;
    logic [4:0] ri2;
    logic [5:0] oc2;
    logic [5:0] q2[$];

    nexus_hier_bitset #(.L1_SIZE(4), .L2_SIZE(8), .LOW_FIRST(1)) u2 (
        .i_clk(clk), .i_arst(arst2),
        .i_set_valid(sv2), .i_set_idx(si2),
        .i_clr_valid(cv2), .i_clr_idx(ci2),
        .i_query_valid(qv2),
        .o_res_valid(rv2), .o_res_found(rf2), .o_res_idx(ri2),
        .o_empty(em2), .o_occupancy(oc2)
    );

    always @(negedge clk) begin
        logic [8:0] e;
        if (rv0 === 1'b1) begin
            if (q0.size() == 0) chk("u0 unexpected result", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("u0 res_found", {31'd0, rf0}, {31'd0, e[8]});
                chk("u0 res_idx", {24'd0, ri0}, {24'd0, e[7:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) chk("u1 unexpected result", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("u1 res_found", {31'd0, rf1}, {31'd0, e[8]});
                chk("u1 res_idx", {24'd0, ri1}, {24'd0, e[7:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (rv2 === 1'b1) begin
            if (q2.size() == 0) chk("u2 unexpected result", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                chk("u2 res_found", {31'd0, rf2}, {31'd0, e[5]});
                chk("u2 res_idx", {27'd0, ri2}, {27'd0, e[4:0]});
            end
        end
    end

    task automatic idle();
        sv0 = 0; cv0 = 0; qv0 = 0;
        sv1 = 0; cv1 = 0; qv1 = 0;
        sv2 = 0; cv2 = 0; qv2 = 0;
    endtask

    initial begin
        arst0 = 1; arst2 = 1;
        si0 = 0; ci0 = 0; si1 = 0; ci1 = 0; si2 = 0; ci2 = 0;
        idle();
        tick(); tick();
        chk("reset res_valid", {31'd0, rv0}, 32'd0);
        chk("reset res_found", {31'd0, rf0}, 32'd0);
        chk("reset res_idx", {24'd0, ri0}, 32'd0);
        chk("reset empty", {31'd0, em0}, 32'd1);
        chk("reset occupancy", {23'd0, oc0}, 32'd0);
        arst0 = 0; arst2 = 0;

        // Low-first search across three rows
        sv0 = 1; si0 = 8'h37; tick();
        chk("first set empty", {31'd0, em0}, 32'd0);
        si0 = 8'hA2; tick();
        si0 = 8'h35; tick();
        sv0 = 0; qv0 = 1; q0.push_back({1'b1, 8'h35}); tick();
        qv0 = 0;
        chk("three sets occupancy", {23'd0, oc0}, occ(3));

        // Clears plus a same-row set and clear in one cycle
        cv0 = 1; ci0 = 8'h37; tick();
        ci0 = 8'h35; sv0 = 1; si0 = 8'h3A; tick();
        sv0 = 0; ci0 = 8'hA2; tick();
        cv0 = 0; qv0 = 1; q0.push_back({1'b1, 8'h3A}); tick();
        qv0 = 0;
        chk("mixed update occupancy", {23'd0, oc0}, occ(1));
        cv0 = 1; ci0 = 8'h3A; tick();
        cv0 = 0;
        chk("drain empty", {31'd0, em0}, 32'd1);
        chk("drain occupancy", {23'd0, oc0}, occ(0));

        // Same-bucket set and clear: set wins
        sv0 = 1; si0 = 8'h40; cv0 = 1; ci0 = 8'h40; tick();
        sv0 = 0; cv0 = 0;
        chk("set wins empty", {31'd0, em0}, 32'd0);
        chk("set wins occupancy", {23'd0, oc0}, occ(1));
        cv0 = 1; ci0 = 8'h40; tick();
        cv0 = 0;
        chk("clear 0x40 empty", {31'd0, em0}, 32'd1);
        chk("clear 0x40 occupancy", {23'd0, oc0}, occ(0));
        qv0 = 1; q0.push_back(9'h000); tick();
        qv0 = 0;

        // Redundant updates are no-ops
        cv0 = 1; ci0 = 8'h40; tick();
        cv0 = 0;
        chk("redundant clear occupancy", {23'd0, oc0}, occ(0));
        sv0 = 1; si0 = 8'h22; tick(); tick();
        sv0 = 0;
        chk("redundant set occupancy", {23'd0, oc0}, occ(1));
        cv0 = 1; ci0 = 8'h22; tick();
        cv0 = 0;

        // Query sees the snapshot at issue, not the same-cycle clear
        sv0 = 1; si0 = 8'h10; tick();
        sv0 = 0;
        qv0 = 1; cv0 = 1; ci0 = 8'h10; q0.push_back({1'b1, 8'h10}); tick();
        cv0 = 0; q0.push_back(9'h000); tick();
        qv0 = 0;

        // Back-to-back queries while filling
        for (int i = 0; i < 4; i++) begin
            sv0 = 1; si0 = 8'(8'h80 - 8'h10 * i); qv0 = 1;
            if (i == 0) q0.push_back(9'h000);
            else q0.push_back({1'b1, 8'(8'h80 - 8'h10 * (i - 1))});
            tick();
        end
        sv0 = 0; q0.push_back({1'b1, 8'h50}); tick();
        qv0 = 0;
        chk("fill occupancy", {23'd0, oc0}, occ(4));

        // High-first instance
        sv1 = 1; si1 = 8'h05; tick();
        si1 = 8'hF1; tick();
        sv1 = 0; qv1 = 1; q1.push_back({1'b1, 8'hF1}); tick();
        qv1 = 0; cv1 = 1; ci1 = 8'hF1; tick();
        cv1 = 0; qv1 = 1; q1.push_back({1'b1, 8'h05}); tick();
        qv1 = 0; sv1 = 1; si1 = 8'h07; tick();
        sv1 = 0; qv1 = 1; q1.push_back({1'b1, 8'h07}); tick();
        qv1 = 0;
        chk("u1 occupancy", {23'd0, oc1}, occ(2));

        // Small geometry and reset mid-query
        sv2 = 1; si2 = 5'd31; tick();
        si2 = 5'd0; tick();
        sv2 = 0; qv2 = 1; q2.push_back({1'b1, 5'd0}); tick();
        qv2 = 0; cv2 = 1; ci2 = 5'd0; tick();
        cv2 = 0; qv2 = 1; q2.push_back({1'b1, 5'd31}); tick();
        qv2 = 0; tick(); tick(); tick();
        sv2 = 1; si2 = 5'd0; tick();
        sv2 = 0; qv2 = 1; tick();
        qv2 = 0;
        #2 arst2 = 1;
        #1;
        chk("u2 reset empty", {31'd0, em2}, 32'd1);
        chk("u2 reset occupancy", {26'd0, oc2}, 32'd0);
        tick(); tick();
        arst2 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("u2 no pulse after reset", {31'd0, rv2}, 32'd0);
        end
        qv2 = 1; q2.push_back(6'h00); tick();
        qv2 = 0;

        repeat (5) tick();
        chk("u0 pending results", 32'(q0.size()), 32'd0);
        chk("u1 pending results", 32'(q1.size()), 32'd0);
        chk("u2 pending results", 32'(q2.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
